// File: rtl/demux8_pkg.sv
// Shared types and constants for the 8-slot bit collector.
// Imported by the interface, the decoder and the top.
package demux8_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    function automatic logic [3:0] popcnt(input logic [DATA_W-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/demux8_collect_if.sv
// Write/read handshake bundle of the bit collector.
// The producer/consumer side uses master; the block uses slave.
interface demux8_collect_if;
    import demux8_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  S;
    logic              D;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Y;
    logic [3:0]        fill_cnt;
    logic              dup_err;

    modport master (
        output in_valid, S, D, out_ready,
        input  in_ready, out_valid, Y, fill_cnt, dup_err
    );

    modport slave (
        input  in_valid, S, D, out_ready,
        output in_ready, out_valid, Y, fill_cnt, dup_err
    );

endinterface

// File: rtl/demux8_dec.sv
// 3-to-8 one-hot decoder of the slot select, gated by the accept.
// Produces the per-bit write enables.
module demux8_dec
    import demux8_pkg::*;
(
    input  logic              i_en,
    input  logic [SEL_W-1:0]  i_sel,
    output logic [DATA_W-1:0] o_we
);

    always_comb begin
        o_we = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_we[i] = i_en && (i_sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/demux8_collect.sv
// Collects eight individually addressed bits into a byte and
// holds it until the consumer takes it.
module demux8_collect
    import demux8_pkg::*;
#(
    parameter bit OVERWRITE = 1'b0
) (
    input logic             clk,
    input logic             rst,
    demux8_collect_if.slave bus
);

    state_t            r_state;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_y;
    logic [3:0]        r_cnt;
    logic              r_dup;

    logic              w_acc;
    logic              w_dup;
    logic [DATA_W-1:0] w_we;
    logic [DATA_W-1:0] w_upd;
    logic [DATA_W-1:0] w_mask_nxt;

    assign w_acc = bus.in_valid && (r_state == COLLECT);

    demux8_dec u_dec (
        .i_en  (w_acc),
        .i_sel (bus.S),
        .o_we  (w_we)
    );

    // Filled slots only take new data when overwrite is enabled
    assign w_dup      = |(w_we & r_mask);
    assign w_upd      = OVERWRITE ? w_we : (w_we & ~r_mask);
    assign w_mask_nxt = r_mask | w_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
            r_mask  <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_dup   <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    r_mask <= w_mask_nxt;
                    r_cnt  <= popcnt(w_mask_nxt);
                    r_y    <= (r_y & ~w_upd)
                            | (w_upd & {DATA_W{bus.D}});
                    r_dup  <= w_dup && !OVERWRITE;
                    if (&w_mask_nxt) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    r_dup <= 1'b0;
                    if (bus.out_ready) begin
                        r_state <= COLLECT;
                        r_mask  <= '0;
                        r_y     <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == COLLECT);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.Y         = r_y;
    assign bus.fill_cnt  = r_cnt;
    assign bus.dup_err   = r_dup;

endmodule

// File: tb/tb_demux8_collect.sv
// Directed bench for demux8_collect, both OVERWRITE settings
// driven side by side with identical stimulus.
module tb_demux8_collect;
    import demux8_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demux8_collect_if b0 ();
    demux8_collect_if b1 ();

    demux8_collect #(.OVERWRITE(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    demux8_collect #(.OVERWRITE(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic d);
        b0.in_valid = v;
        b0.S        = s;
        b0.D        = d;
        b1.in_valid = v;
        b1.S        = s;
        b1.D        = d;
    endtask

    task automatic set_ordy(input logic r);
        b0.out_ready = r;
        b1.out_ready = r;
    endtask

    task automatic wr(input logic [2:0] s, input logic d);
        drive(1'b1, s, d);
        tick();
        drive(1'b0, 3'd0, 1'b0);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), v[i]);
        end
    endtask

    initial begin
        logic [7:0] pat;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0);
        set_ordy(1'b0);
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk("rst_in_ready", 8'(b0.in_ready), 8'h01);
        chk("rst_out_valid", 8'(b0.out_valid), 8'h00);
        chk("rst_y", b0.Y, 8'h00);
        chk("rst_cnt", 8'(b0.fill_cnt), 8'h00);
        chk("rst_dup", 8'(b0.dup_err), 8'h00);
        rst = 1'b0;

        // in-order fill -> 8'h4D
        wr(3'd0, 1'b1);
        wr(3'd1, 1'b0);
        wr(3'd2, 1'b1);
        wr(3'd3, 1'b1);
        chk("inord_cnt4", 8'(b0.fill_cnt), 8'h04);
        chk("inord_ovld_lo", 8'(b0.out_valid), 8'h00);
        wr(3'd4, 1'b0);
        wr(3'd5, 1'b0);
        wr(3'd6, 1'b1);
        wr(3'd7, 1'b0);
        chk("inord_ovld", 8'(b0.out_valid), 8'h01);
        chk("inord_irdy", 8'(b0.in_ready), 8'h00);
        chk("inord_y", b0.Y, 8'h4D);
        chk("inord_cnt8", 8'(b0.fill_cnt), 8'h08);
        set_ordy(1'b1);
        tick();
        set_ordy(1'b0);
        chk("inord_rel_ovld", 8'(b0.out_valid), 8'h00);
        chk("inord_rel_y", b0.Y, 8'h00);
        chk("inord_rel_cnt", 8'(b0.fill_cnt), 8'h00);

        // scrambled fill with backpressure
        wr(3'd7, 1'b1);
        wr(3'd3, 1'b1);
        wr(3'd0, 1'b1);
        wr(3'd5, 1'b1);
        wr(3'd1, 1'b1);
        wr(3'd6, 1'b1);
        wr(3'd2, 1'b1);
        chk("scr_cnt7", 8'(b0.fill_cnt), 8'h07);
        wr(3'd4, 1'b1);
        chk("scr_y", b0.Y, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 1'b0);
            tick();
            chk("scr_hold_ovld", 8'(b0.out_valid), 8'h01);
            chk("scr_hold_y", b0.Y, 8'hFF);
        end
        drive(1'b0, 3'd0, 1'b0);
        chk("scr_hold_cnt", 8'(b0.fill_cnt), 8'h08);
        set_ordy(1'b1);
        tick();
        chk("scr_rel_ovld", 8'(b0.out_valid), 8'h00);
        chk("scr_rel_y", b0.Y, 8'h00);
        chk("scr_rel_cnt", 8'(b0.fill_cnt), 8'h00);

        // duplicate write, out_ready left high in COLLECT
        wr(3'd2, 1'b1);
        chk("dup_first_err0", 8'(b0.dup_err), 8'h00);
        wr(3'd2, 1'b0);
        chk("dup_err0", 8'(b0.dup_err), 8'h01);
        chk("dup_y0", b0.Y, 8'h04);
        chk("dup_cnt0", 8'(b0.fill_cnt), 8'h01);
        chk("dup_err1", 8'(b1.dup_err), 8'h00);
        chk("dup_y1", b1.Y, 8'h00);
        chk("dup_cnt1", 8'(b1.fill_cnt), 8'h01);
        chk("dup_irdy", 8'(b0.in_ready), 8'h01);
        tick();
        chk("dup_pulse_end0", 8'(b0.dup_err), 8'h00);
        chk("dup_never1", 8'(b1.dup_err), 8'h00);

        // reset mid-frame (slot 2 already filled)
        set_ordy(1'b0);
        wr(3'd0, 1'b1);
        wr(3'd1, 1'b1);
        wr(3'd3, 1'b1);
        wr(3'd4, 1'b1);
        chk("mid_cnt5", 8'(b0.fill_cnt), 8'h05);
        chk("mid_y0", b0.Y, 8'h1F);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_y", b0.Y, 8'h00);
        chk("mid_rst_cnt", 8'(b0.fill_cnt), 8'h00);
        chk("mid_rst_irdy", 8'(b0.in_ready), 8'h01);
        #1 rst = 1'b0;
        wr_byte(8'hA5);
        chk("post_rst_ovld", 8'(b0.out_valid), 8'h01);
        chk("post_rst_y0", b0.Y, 8'hA5);
        chk("post_rst_y1", b1.Y, 8'hA5);

        // back-to-back frames with out_ready tied high
        set_ordy(1'b1);
        tick();
        chk("b2b_rel", 8'(b0.out_valid), 8'h00);
        wr_byte(8'h3C);
        chk("b2b_a_ovld", 8'(b0.out_valid), 8'h01);
        chk("b2b_a_y", b0.Y, 8'h3C);
        wr(3'd0, 1'b1);
        chk("b2b_a_1cyc", 8'(b0.out_valid), 8'h00);
        chk("b2b_ign_y", b0.Y, 8'h00);
        chk("b2b_ign_cnt", 8'(b0.fill_cnt), 8'h00);
        pat = 8'hC3;
        wr(3'd0, pat[0]);
        chk("b2b_first_acc", 8'(b0.fill_cnt), 8'h01);
        for (int i = 1; i < 8; i++) begin
            wr(3'(i), pat[i]);
        end
        chk("b2b_b_ovld", 8'(b0.out_valid), 8'h01);
        chk("b2b_b_y", b0.Y, 8'hC3);
        tick();
        chk("b2b_b_1cyc", 8'(b0.out_valid), 8'h00);
        chk("b2b_b_irdy", 8'(b0.in_ready), 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux8_collect.md
DEMUX8_COLLECT -- requirements
Module: demux8_collect

Interface
REQ-001 Parameter: OVERWRITE, default 0, meaning 0 = reject writes to an already-filled slot, 1 = accept them.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: in_valid  input  1  write request present.
REQ-005 Port: in_ready  output  1  block accepts a write this cycle.
REQ-006 Port: S  input  3  target bit index 0..7.
REQ-007 Port: D  input  1  bit value to place at index S.
REQ-008 Port: out_valid  output  1  assembled byte available.
REQ-009 Port: out_ready  input  1  consumer takes the byte.
REQ-010 Port: Y  output  8  assembled byte, with Y[i] the bit last accepted for S == i.
REQ-011 Port: fill_cnt  output  4  number of distinct slots filled, 0..8.
REQ-012 Port: dup_err  output  1  one-cycle pulse on a rejected duplicate write.

Function
REQ-013 The block SHALL have two states: COLLECT and HOLD.
REQ-014 in_ready SHALL be 1 in COLLECT and 0 in HOLD, decoded directly from state with no input dependence.
REQ-015 out_valid SHALL be 1 in HOLD and 0 in COLLECT.
REQ-016 An accept SHALL occur when in_valid && in_ready at a clock edge.
REQ-017 On an accept to an empty slot, the block SHALL set Y[S] <= D and mask[S] <= 1.
REQ-018 On an accept to a filled slot with OVERWRITE=1, the block SHALL set Y[S] <= D, leave the mask unchanged, and not assert dup_err.
REQ-019 On an accept to a filled slot with OVERWRITE=0, the block SHALL leave Y and the mask unchanged and assert dup_err for exactly the next cycle.
REQ-020 fill_cnt SHALL equal the popcount of mask and be registered, so it reflects an accept in the cycle after it.
REQ-021 When an accept makes the mask all ones, the block SHALL enter HOLD on that edge, so out_valid is 1 in the following cycle (latency 1).
REQ-022 In HOLD, Y SHALL remain stable and all in_valid activity SHALL be ignored.
REQ-023 In HOLD, while out_ready is 0, the block SHALL remain in HOLD indefinitely.
REQ-024 In HOLD with out_ready == 1, the block SHALL return to COLLECT and clear the mask, fill_cnt and Y to 0 on that edge.
REQ-025 The next byte's first accept SHALL be possible in the cycle immediately after release (throughput: one byte per 9 cycles minimum).
REQ-026 out_ready SHALL have no effect in COLLECT.
REQ-027 The block SHALL not latch combinationally; Y SHALL be driven by flops only.

Reset
REQ-028 While rst is 1, the block SHALL hold state = COLLECT, mask = 0, Y = 8'h00, fill_cnt = 0 and dup_err = 0; in_ready is therefore 1 and out_valid is 0.
REQ-029 An assertion of rst mid-frame or in HOLD SHALL discard the partial or held byte immediately, without waiting for a clock edge.
REQ-030 On the first edge after rst deasserts, the block SHALL accept normally.

Structure
REQ-031 Package demux8_pkg SHALL contain the state enum {COLLECT, HOLD}, the constant DATA_W = 8 and the constant SEL_W = 3.
REQ-032 Sub-module demux8_dec (a 3-to-8 one-hot decoder of S, gated by the accept) SHALL generate the per-bit write enables; it is the only sub-module.

Verification
REQ-033 Scenario, in-order fill: writes S = 0..7 with D = 1,0,1,1,0,0,1,0 on consecutive cycles -> out_valid in cycle 9, Y = 8'h4D, fill_cnt = 8.
REQ-034 Scenario, scrambled fill with backpressure: S order 7,3,0,5,1,6,2,4, all D = 1, out_ready held 0 for 5 cycles -> Y = 8'hFF stable, in_valid ignored, release on the out_ready edge, then Y = 0 and fill_cnt = 0.
REQ-035 Scenario, duplicate with OVERWRITE=0: S=2 D=1, then S=2 D=0 -> Y[2] stays 1, dup_err high for 1 cycle, fill_cnt stays 1.
REQ-036 Scenario, duplicate with OVERWRITE=1: the same stimulus as REQ-035 -> Y[2] = 0, dup_err never asserted, fill_cnt = 1.
REQ-037 Scenario, reset mid-frame: 5 slots filled, rst pulsed between edges -> immediate Y = 0, fill_cnt = 0, in_ready = 1; a subsequent 8-write frame completes normally.
REQ-038 Scenario, back-to-back frames: out_ready tied to 1 with continuous writes -> each frame's out_valid lasts 1 cycle and the next frame's first write is accepted in the following cycle.
